// File: rtl/mul_fu.sv
// Pipelined RV32M multiply lane: MUL/MULH/MULHSU/MULHU onto the CDB.
// Define MUL_FU_FLUSH_EN to add a flush input that kills in-flight ops.
module mul_fu #(
    parameter int XLEN   = 32,
    parameter int PRF_W  = 6,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             avail,
    input  logic             valid,
    input  logic [2:0]       fun,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [PRF_W-1:0] dst,
    output logic             cdb_valid,
    output logic [PRF_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_value,
    input  logic             cdb_grant
`ifdef MUL_FU_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    logic              kill;
    logic              stall;
    logic              accept;
    logic              sgn_a;
    logic              sgn_b;
    logic [XLEN:0]     ext_a;
    logic [XLEN:0]     ext_b;
    logic [2*XLEN-1:0] wide_a;
    logic [2*XLEN-1:0] wide_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res;

    logic [STAGES-1:0] v_q;
    logic [PRF_W-1:0]  tag_q [STAGES];
    logic [XLEN-1:0]   val_q [STAGES];

`ifdef MUL_FU_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    assign stall  = cdb_valid && !cdb_grant;
    assign avail  = !stall && !kill;
    assign accept = valid && avail;

    // One extra sign bit per operand lets all four variants share a
    // single multiplier; the low 2*XLEN bits of the product are exact.
    assign sgn_a  = (fun == 3'd1) || (fun == 3'd2);
    assign sgn_b  = (fun == 3'd1);
    assign ext_a  = {sgn_a & op_a[XLEN-1], op_a};
    assign ext_b  = {sgn_b & op_b[XLEN-1], op_b};
    assign wide_a = {{(XLEN-1){ext_a[XLEN]}}, ext_a};
    assign wide_b = {{(XLEN-1){ext_b[XLEN]}}, ext_b};
    assign prod   = wide_a * wide_b;

    always_comb begin
        res = '0;
        unique case (1'b1)
            (fun == 3'd0): res = prod[XLEN-1:0];
            (fun == 3'd1 || fun == 3'd2 || fun == 3'd3):
                res = prod[2*XLEN-1:XLEN];
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                tag_q[i] <= '0;
                val_q[i] <= '0;
            end
        end else if (kill) begin
            v_q <= '0;
        end else if (!stall) begin
            v_q[0]   <= accept;
            tag_q[0] <= accept ? dst : '0;
            val_q[0] <= accept ? res : '0;
            for (int i = 1; i < STAGES; i++) begin
                v_q[i]   <= v_q[i-1];
                tag_q[i] <= tag_q[i-1];
                val_q[i] <= val_q[i-1];
            end
        end
    end

    assign cdb_valid = v_q[STAGES-1];
    assign cdb_tag   = tag_q[STAGES-1];
    assign cdb_value = val_q[STAGES-1];

endmodule

// File: tb/tb_mul_fu.sv
// Random + directed bench for mul_fu against a queue-based reference.
// Exercises the flush port when MUL_FU_FLUSH_EN is defined.
module tb_mul_fu;

    localparam int XLEN   = 32;
    localparam int PRF_W  = 6;
    localparam int STAGES = 3;

    logic             clk;
    logic             rst_n;
    logic             avail;
    logic             valid;
    logic [2:0]       fun;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [PRF_W-1:0] dst;
    logic             cdb_valid;
    logic [PRF_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_value;
    logic             cdb_grant;
    logic             flush;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [PRF_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } exp_t;

    exp_t q[$];

    mul_fu #(.XLEN(XLEN), .PRF_W(PRF_W), .STAGES(STAGES)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .avail(avail),
        .valid(valid),
        .fun(fun),
        .op_a(op_a),
        .op_b(op_b),
        .dst(dst),
        .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag),
        .cdb_value(cdb_value),
        .cdb_grant(cdb_grant)
`ifdef MUL_FU_FLUSH_EN
        ,
        .flush(flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tg, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tg, obs, exp);
        end
    endtask

    // Reference result straight from the ISA definition in 64-bit math.
    function automatic logic [XLEN-1:0] ref_mul(input logic [2:0] f,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            default: return '0;
        endcase
    endfunction

    // Scoreboard: accepts push, granted results pop in order.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (cdb_valid && cdb_grant) begin
                if (q.size() == 0) begin
                    chk("spurious_wb", 64'(cdb_tag), 64'hffff);
                end else begin
                    e = q.pop_front();
                    chk("cdb_tag", 64'(cdb_tag), 64'(e.tag));
                    chk("cdb_value", 64'(cdb_value), 64'(e.val));
                end
            end
            if (valid && avail) begin
                e.tag = dst;
                e.val = ref_mul(fun, op_a, op_b);
                q.push_back(e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [PRF_W-1:0] d);
        valid = 1'b1;
        fun   = f;
        op_a  = a;
        op_b  = b;
        dst   = d;
    endtask

    task automatic run_one(input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [PRF_W-1:0] d,
                           input logic [31:0] exp);
        drive(f, a, b, d);
        tick();
        valid = 1'b0;
        repeat (STAGES - 1) begin
            @(negedge clk);
            chk("early_valid", 64'(cdb_valid), 64'd0);
            tick();
        end
        @(negedge clk);
        chk("lat_valid", 64'(cdb_valid), 64'd1);
        chk("lat_tag", 64'(cdb_tag), 64'(d));
        chk("lat_value", 64'(cdb_value), 64'(exp));
        tick();
        @(negedge clk);
        chk("one_cycle", 64'(cdb_valid), 64'd0);
        tick();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'hffff_ffff;
            1: return 32'h8000_0000;
            2: return 32'h7fff_ffff;
            3: return 32'(($urandom_range(0, 3)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        fun = '0;
        op_a = '0;
        op_b = '0;
        dst = '0;
        cdb_grant = 1'b0;
        flush = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_tag", 64'(cdb_tag), 64'd0);
        chk("rst_value", 64'(cdb_value), 64'd0);
        chk("rst_avail", 64'(avail), 64'd1);
        tick();
        cdb_grant = 1'b1;

        run_one(3'd0, 32'd7, 32'd6, 6'd5, 32'd42);
        run_one(3'd1, 32'hffff_ffff, 32'hffff_ffff, 6'd6, 32'h0);
        run_one(3'd3, 32'hffff_ffff, 32'hffff_ffff, 6'd7, 32'hffff_fffe);
        run_one(3'd2, 32'hffff_ffff, 32'hffff_ffff, 6'd8, 32'hffff_ffff);
        run_one(3'd1, 32'h8000_0000, 32'h8000_0000, 6'd10, 32'h4000_0000);
        run_one(3'd4, 32'd3, 32'd3, 6'd9, 32'd0);

        // Back-pressure: tag 4 is held by issue while the CDB refuses.
        for (int t = 1; t <= 3; t++) begin
            drive(3'($urandom_range(0, 3)), $urandom, $urandom, 6'(t));
            tick();
        end
        drive(3'($urandom_range(0, 3)), $urandom, $urandom, 6'd4);
        cdb_grant = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_avail", 64'(avail), 64'd0);
            chk("bp_valid", 64'(cdb_valid), 64'd1);
            chk("bp_tag", 64'(cdb_tag), 64'd1);
            tick();
        end
        cdb_grant = 1'b1;
        @(negedge clk);
        chk("bp_release_avail", 64'(avail), 64'd1);
        chk("bp_release_tag", 64'(cdb_tag), 64'd1);
        tick();
        valid = 1'b0;
        for (int t = 2; t <= 4; t++) begin
            @(negedge clk);
            chk("bp_order_valid", 64'(cdb_valid), 64'd1);
            chk("bp_order_tag", 64'(cdb_tag), 64'(t));
            tick();
        end
        @(negedge clk);
        chk("bp_empty", 64'(cdb_valid), 64'd0);
        tick();

        // Reset while two ops are in flight and the CDB is stalled.
        drive(3'd0, 32'd11, 32'd13, 6'd20);
        tick();
        drive(3'd0, 32'd17, 32'd19, 6'd21);
        tick();
        valid = 1'b0;
        repeat (STAGES - 2) tick();
        chk("stall_setup", 64'(cdb_valid), 64'd1);
        cdb_grant = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        drive(3'd0, 32'd2, 32'd2, 6'd33);
        tick();
        rst_n = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 64'(cdb_valid), 64'd0);
        chk("mrst_tag", 64'(cdb_tag), 64'd0);
        chk("mrst_value", 64'(cdb_value), 64'd0);
        chk("mrst_avail", 64'(avail), 64'd1);
        tick();
        cdb_grant = 1'b1;
        repeat (STAGES + 3) begin
            @(negedge clk);
            chk("mrst_no_wb", 64'(cdb_valid), 64'd0);
            tick();
        end

`ifdef MUL_FU_FLUSH_EN
        for (int t = 10; t <= 12; t++) begin
            drive(3'd0, $urandom, $urandom, 6'(t));
            tick();
        end
        drive(3'd0, 32'd5, 32'd5, 6'd13);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_avail", 64'(avail), 64'd0);
        tick();
        flush = 1'b0;
        valid = 1'b0;
        repeat (STAGES + 2) begin
            @(negedge clk);
            chk("flush_no_wb", 64'(cdb_valid), 64'd0);
            tick();
        end
        run_one(3'd0, 32'd9, 32'd9, 6'd14, 32'd81);
`endif

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 7)
                drive(3'($urandom_range(0, 7)), pick(), pick(),
                      6'($urandom_range(0, 63)));
            else
                valid = 1'b0;
            cdb_grant = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            chk("avail_rule", 64'(avail),
                64'(!(cdb_valid && !cdb_grant)));
            tick();
        end
        valid = 1'b0;
        cdb_grant = 1'b1;
        repeat (STAGES + 2) tick();
        chk("drain", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
